// File: rtl/flash_read_responder.sv
// rtl/flash_read_responder.sv - Avalon-MM pipelined read responder backed by a synchronous ROM port
module flash_read_responder #(
  parameter int          DEPTH      = 4,
  parameter int          EXTRA_WAIT = 0,
  parameter logic [22:0] MAX_WORD   = 23'h7FFF,
  parameter logic [31:0] OOB_DATA   = 32'h0000_0000
) (
  input  logic                   fetch_clock,
  input  logic                   reset,
  input  logic                   flash_mem_read,
  input  logic [22:0]            flash_mem_address,
  output logic                   flash_mem_waitrequest,
  output logic [31:0]            flash_mem_readdata,
  output logic                   flash_mem_readdatavalid,
  output logic [22:0]            rom_address,
  output logic                   rom_rden,
  input  logic [31:0]            rom_q,
  input  logic                   stall_inject,
  output logic [$clog2(DEPTH):0] pending_count,
  output logic                   oob_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // WAIT exits when the counter reaches zero, so load one less than the wait length
  localparam logic [3:0] WAIT_LOAD = (EXTRA_WAIT > 0) ? 4'(EXTRA_WAIT - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t        state;
  logic [22:0]   queue_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [22:0]   addr_reg;
  logic [3:0]    wait_cnt;
  logic [31:0]   readdata_r;
  logic          readdatavalid_r;
  logic          push;
  logic          pop;
  logic [22:0]   head_addr;

  // Backpressure looks only at the registered count; a same-cycle pop does not free a slot early
  assign flash_mem_waitrequest   = (count == CW'(DEPTH)) || stall_inject;
  assign push                    = flash_mem_read && !flash_mem_waitrequest;
  assign pop                     = ((state == S_IDLE) || (state == S_RESP)) && (count != '0);
  assign head_addr               = queue_mem[head];
  assign pending_count           = count;
  assign flash_mem_readdata      = readdata_r;
  assign flash_mem_readdatavalid = readdatavalid_r;

  // Request address storage; contents are don't-care until written, so no reset
  always_ff @(posedge fetch_clock) begin
    if (push) begin
      queue_mem[tail] <= flash_mem_address;
    end
  end

  // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge fetch_clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Service engine: pop, drive the ROM, optionally wait, capture, then present the response
  always_ff @(posedge fetch_clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      addr_reg        <= '0;
      rom_address     <= '0;
      rom_rden        <= 1'b0;
      wait_cnt        <= '0;
      readdata_r      <= '0;
      readdatavalid_r <= 1'b0;
      oob_error       <= 1'b0;
    end else begin
      readdatavalid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            addr_reg    <= head_addr;
            rom_address <= head_addr;
            rom_rden    <= (head_addr <= MAX_WORD);
            state       <= S_READ;
          end
        end
        S_READ: begin
          rom_rden <= 1'b0;
          if (EXTRA_WAIT > 0) begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_WAIT;
          end else begin
            state <= S_CAPTURE;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          readdatavalid_r <= 1'b1;
          if (addr_reg > MAX_WORD) begin
            readdata_r <= OOB_DATA;
            oob_error  <= 1'b1;
          end else begin
            readdata_r <= rom_q;
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (pop) begin
            addr_reg    <= head_addr;
            rom_address <= head_addr;
            rom_rden    <= (head_addr <= MAX_WORD);
            state       <= S_READ;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_responder.sv
// tb/tb_flash_read_responder.sv - scoreboard bench for flash_read_responder (EXTRA_WAIT 0 and 2 instances)
module tb_flash_read_responder;

  localparam logic [22:0] MAXW = 23'h7FFF;
  localparam logic [31:0] OOBD = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       rd;
  logic [1:0][22:0] addr;
  logic [1:0]       stall;
  logic [1:0][31:0] rom_q;
  logic [1:0]       wr;
  logic [1:0][31:0] rdata;
  logic [1:0]       rvalid;
  logic [1:0][22:0] rom_addr;
  logic [1:0]       rden;
  logic [1:0][2:0]  pcount;
  logic [1:0]       oob;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          rt0[$];
  int          rt1[$];
  int          resp_n[2];
  int          last_resp[2];
  int          acc_cyc[2];
  int          rden_n[2];
  logic [22:0] last_rom[2];
  logic [1:0]  prev_valid;
  logic [1:0]  full_seen;
  logic [31:0] mon_e;

  flash_read_responder #(.DEPTH(4), .EXTRA_WAIT(0), .MAX_WORD(MAXW), .OOB_DATA(OOBD)) u0 (
    .fetch_clock(clk), .reset(rst),
    .flash_mem_read(rd[0]), .flash_mem_address(addr[0]),
    .flash_mem_waitrequest(wr[0]), .flash_mem_readdata(rdata[0]),
    .flash_mem_readdatavalid(rvalid[0]), .rom_address(rom_addr[0]),
    .rom_rden(rden[0]), .rom_q(rom_q[0]), .stall_inject(stall[0]),
    .pending_count(pcount[0]), .oob_error(oob[0])
  );

  flash_read_responder #(.DEPTH(4), .EXTRA_WAIT(2), .MAX_WORD(MAXW), .OOB_DATA(OOBD)) u1 (
    .fetch_clock(clk), .reset(rst),
    .flash_mem_read(rd[1]), .flash_mem_address(addr[1]),
    .flash_mem_waitrequest(wr[1]), .flash_mem_readdata(rdata[1]),
    .flash_mem_readdatavalid(rvalid[1]), .rom_address(rom_addr[1]),
    .rom_rden(rden[1]), .rom_q(rom_q[1]), .stall_inject(stall[1]),
    .pending_count(pcount[1]), .oob_error(oob[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rom_word(input logic [22:0] a);
    if (a == 23'h10) return 32'hA1B2C3D4;
    return {a[7:0], 1'b1, a} ^ 32'h5C3A_9E17;
  endfunction

  function automatic logic [31:0] expected_word(input logic [22:0] a);
    return (a > MAXW) ? OOBD : rom_word(a);
  endfunction

  // ROM contents with one-cycle read latency; q holds when not enabled
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rden[k]) rom_q[k] <= rom_word(rom_addr[k]);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a response is presented
  initial begin
    prev_valid = 2'b00;
    resp_n = '{0, 0};
    rden_n = '{0, 0};
    full_seen = 2'b00;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (rvalid[k]) begin
          chk("no_back_to_back_valid", {31'd0, prev_valid[k]}, 32'd0);
          if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
            chk("unexpected_valid", 32'd1, 32'd0);
          end else begin
            if (k == 0) mon_e = exp0.pop_front();
            else        mon_e = exp1.pop_front();
            chk("readdata", rdata[k], mon_e);
          end
          resp_n[k]++;
          last_resp[k] = cyc;
          if (k == 0) rt0.push_back(cyc);
          else        rt1.push_back(cyc);
        end
        prev_valid[k] = rvalid[k];
        if (rden[k]) begin
          chk("rden_inbounds", {31'd0, rom_addr[k] <= MAXW}, 32'd1);
          rden_n[k]++;
          last_rom[k] = rom_addr[k];
        end
        if (pcount[k] == 3'd4) begin
          chk("wr_when_full", {31'd0, wr[k]}, 32'd1);
          full_seen[k] = 1'b1;
        end
        if (stall[k]) chk("wr_when_stalled", {31'd0, wr[k]}, 32'd1);
      end
    end
  end

  task automatic issue(input int k, input logic [22:0] a);
    int n;
    rd[k] = 1'b1;
    addr[k] = a;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!wr[k]) break;
      @(posedge clk);
      #1;
    end
    if (n == 200) begin
      chk("accept_timeout", 32'd0, 32'd1);
      rd[k] = 1'b0;
      return;
    end
    if (k == 0) exp0.push_back(expected_word(a));
    else        exp1.push_back(expected_word(a));
    acc_cyc[k] = cyc;
    @(posedge clk);
    #1;
    rd[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while ((k == 0 ? exp0.size() : exp1.size()) != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input int k);
    chk("rst_readdatavalid", {31'd0, rvalid[k]}, 32'd0);
    chk("rst_readdata", rdata[k], 32'd0);
    chk("rst_rom_rden", {31'd0, rden[k]}, 32'd0);
    chk("rst_rom_address", {9'd0, rom_addr[k]}, 32'd0);
    chk("rst_oob_error", {31'd0, oob[k]}, 32'd0);
    chk("rst_pending_count", {29'd0, pcount[k]}, 32'd0);
    chk("rst_waitrequest", {31'd0, wr[k]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 50000", cyc);
    $fatal(1);
  end

  int base;
  int r0;
  logic [2:0] p0;
  logic [22:0] ra;
  int gap;

  initial begin
    rd = '0;
    addr = '0;
    stall = '0;
    rst = 1'b1;
    idle_cycles(2);
    check_reset_values(0);
    check_reset_values(1);
    rst = 1'b0;
    idle_cycles(1);

    // single read, zero extra wait
    base = rden_n[0];
    issue(0, 23'h10);
    drain(0);
    chk("t1_latency", 32'(last_resp[0] - acc_cyc[0]), 32'd4);
    chk("t1_rden_pulses", 32'(rden_n[0] - base), 32'd1);
    chk("t1_rom_address", {9'd0, last_rom[0]}, 32'h10);

    // burst of six, read held high
    rt0.delete();
    full_seen[0] = 1'b0;
    for (int i = 0; i < 6; i++) issue(0, 23'(i));
    drain(0);
    chk("t2_full_seen", {31'd0, full_seen[0]}, 32'd1);
    chk("t2_resp_count", 32'(rt0.size()), 32'd6);
    for (int i = 1; i < 6; i++) begin
      if (i < rt0.size()) chk("t2_spacing", 32'(rt0[i] - rt0[i-1]), 32'd3);
    end

    // extra wait of two cycles
    issue(1, 23'd7);
    drain(1);
    chk("t3_latency", 32'(last_resp[1] - acc_cyc[1]), 32'd6);
    rt1.delete();
    issue(1, 23'd8);
    issue(1, 23'd9);
    drain(1);
    chk("t3_resp_count", 32'(rt1.size()), 32'd2);
    if (rt1.size() == 2) chk("t3_spacing", 32'(rt1[1] - rt1[0]), 32'd5);

    // out-of-bounds request then a normal one
    base = rden_n[0];
    issue(0, 23'h8000);
    drain(0);
    chk("t4_no_rden", 32'(rden_n[0] - base), 32'd0);
    chk("t4_oob_set", {31'd0, oob[0]}, 32'd1);
    issue(0, 23'd1);
    drain(0);
    chk("t4_rden_after", 32'(rden_n[0] - base), 32'd1);
    chk("t4_oob_sticky", {31'd0, oob[0]}, 32'd1);

    // stall during a burst
    base = resp_n[0];
    fork
      begin
        for (int i = 0; i < 8; i++) issue(0, 23'(100 + i));
      end
      begin
        idle_cycles(4);
        stall[0] = 1'b1;
        r0 = resp_n[0];
        p0 = pcount[0];
        idle_cycles(5);
        chk("t5_service_continues", {31'd0, resp_n[0] > r0}, 32'd1);
        chk("t5_no_accept", {31'd0, pcount[0] <= p0}, 32'd1);
        stall[0] = 1'b0;
      end
    join
    drain(0);
    chk("t5_resp_count", 32'(resp_n[0] - base), 32'd8);

    // reset while requests are queued and one is in capture
    rd[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr[0] = 23'(20 + i);
      idle_cycles(1);
    end
    addr[0] = 23'd23;
    @(negedge clk);
    rst = 1'b1;
    rd[0] = 1'b0;
    exp0.delete();
    exp1.delete();
    #1;
    check_reset_values(0);
    idle_cycles(2);
    rst = 1'b0;
    base = resp_n[0] + resp_n[1];
    idle_cycles(10);
    chk("t6_no_valid_after_reset", 32'(resp_n[0] + resp_n[1] - base), 32'd0);
    issue(0, 23'd2);
    drain(0);
    chk("t6_latency", 32'(last_resp[0] - acc_cyc[0]), 32'd4);

    // randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      base = resp_n[k];
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 7) == 0) ra = 23'(32'h8000 + $urandom_range(0, 1000));
        else                           ra = 23'($urandom_range(0, 32767));
        if ($urandom_range(0, 5) == 0) begin
          stall[k] = 1'b1;
          idle_cycles(int'($urandom_range(1, 3)));
          stall[k] = 1'b0;
        end
        issue(k, ra);
        gap = int'($urandom_range(0, 2));
        idle_cycles(gap);
      end
      drain(k);
      chk("rand_resp_count", 32'(resp_n[k] - base), 32'd25);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
